// File: rtl/i2c_slave.sv
// i2c_slave: I2C target at SLAVE_ADDR; scl/sda bus pins, rx_data+rx_valid deliver written bytes, tx_data+tx_req supply read bytes, busy while addressed, stop_det on STOP
module i2c_slave #(
  parameter logic [6:0] SLAVE_ADDR = 7'h42,
  parameter int ACK_HOLD = 300
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl,
  inout  wire        sda,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_req,
  output logic       busy,
  output logic       stop_det
);
  localparam int HW = $clog2(ACK_HOLD + 1);
  typedef enum logic [2:0] {IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE} state_t;
  state_t state, state_n;
  logic [2:0] scl_s, sda_s, cnt, cnt_n;
  logic [7:0] sh, sh_n, rx_data_n;
  logic [HW-1:0] hold_cnt, hold_cnt_n;
  logic oe, oe_n, rw, rw_n, last, last_n, hold_on, hold_on_n;
  logic rx_valid_n, tx_req_n, busy_n, stop_det_n;
  logic rise, fall, start, stop, bit_in, expire;
  assign sda = oe ? 1'b0 : 1'bz;
  assign rise = scl_s[1] & ~scl_s[2];
  assign fall = ~scl_s[1] & scl_s[2];
  assign start = scl_s[1] & ~sda_s[1] & sda_s[2];
  assign stop = scl_s[1] & sda_s[1] & ~sda_s[2];
  assign bit_in = sda_s[1];
  assign expire = hold_on && hold_cnt == HW'(ACK_HOLD - 1);
  always_ff @(posedge clk) begin
    if (reset) begin
      scl_s <= 3'b111;
      sda_s <= 3'b111;
      state <= IDLE;
      cnt <= '0;
      sh <= '0;
      hold_cnt <= '0;
      hold_on <= 1'b0;
      oe <= 1'b0;
      rw <= 1'b0;
      last <= 1'b0;
      rx_data <= '0;
      rx_valid <= 1'b0;
      tx_req <= 1'b0;
      busy <= 1'b0;
      stop_det <= 1'b0;
    end else begin
      scl_s <= {scl_s[1:0], scl};
      sda_s <= {sda_s[1:0], sda};
      state <= state_n;
      cnt <= cnt_n;
      sh <= sh_n;
      hold_cnt <= hold_cnt_n;
      hold_on <= hold_on_n;
      oe <= oe_n;
      rw <= rw_n;
      last <= last_n;
      rx_data <= rx_data_n;
      rx_valid <= rx_valid_n;
      tx_req <= tx_req_n;
      busy <= busy_n;
      stop_det <= stop_det_n;
    end
  end
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    sh_n = sh;
    hold_cnt_n = hold_on ? hold_cnt + 1'b1 : hold_cnt;
    hold_on_n = hold_on;
    oe_n = oe;
    rw_n = rw;
    last_n = last;
    rx_data_n = rx_data;
    rx_valid_n = 1'b0;
    tx_req_n = 1'b0;
    busy_n = busy;
    stop_det_n = 1'b0;
    if (stop) begin
      state_n = IDLE;
      oe_n = 1'b0;
      busy_n = 1'b0;
      stop_det_n = 1'b1;
      hold_on_n = 1'b0;
      last_n = 1'b0;
    end else if (start) begin
      state_n = ADDR;
      cnt_n = '0;
      oe_n = 1'b0;
      busy_n = 1'b0;
      hold_on_n = 1'b0;
      last_n = 1'b0;
    end else begin
      case (state)
        ADDR, WR_DATA: begin
          if (rise) begin
            sh_n = {sh[6:0], bit_in};
            cnt_n = cnt + 3'd1;
            if (cnt == 3'd7) begin
              last_n = 1'b1;
              if (state == WR_DATA) begin
                rx_data_n = {sh[6:0], bit_in};
                rx_valid_n = 1'b1;
              end else if (sh[6:0] == SLAVE_ADDR) begin
                busy_n = 1'b1;
                rw_n = bit_in;
              end else
                state_n = IGNORE;
            end
          end else if (fall && last) begin
            last_n = 1'b0;
            oe_n = 1'b1;
            state_n = state == ADDR ? ADDR_ACK : WR_ACK;
          end
        end
        ADDR_ACK, WR_ACK, RD_ACK: begin
          if (rise && state == ADDR_ACK && rw)
            tx_req_n = 1'b1;
          if (rise && state == RD_ACK) begin
            if (bit_in) begin
              busy_n = 1'b0;
              state_n = IGNORE;
            end else
              tx_req_n = 1'b1;
          end
          // the hold counter starts on the fall that ends the ACK bit
          if (fall) begin
            hold_on_n = 1'b1;
            hold_cnt_n = '0;
          end
          if (expire) begin
            hold_on_n = 1'b0;
            cnt_n = '0;
            if ((state == ADDR_ACK && !rw) || state == WR_ACK) begin
              oe_n = 1'b0;
              state_n = WR_DATA;
            end else begin
              sh_n = tx_data;
              oe_n = ~tx_data[7];
              state_n = RD_DATA;
            end
          end
        end
        RD_DATA: begin
          if (fall) begin
            cnt_n = cnt + 3'd1;
            if (cnt == 3'd7) begin
              oe_n = 1'b0;
              state_n = RD_ACK;
            end else begin
              sh_n = {sh[6:0], 1'b0};
              oe_n = ~sh[6];
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: doc/i2c_slave.md
Name: i2c_slave

Overview:
- I2C target (slave) for the team's I2C master. Sits on the same SCL/SDA pair, responds to one 7-bit address and supports byte writes and byte reads.
- SCL is input only; the master drives it push-pull and no clock stretching is done.
- SDA is open-drain: the block drives it low or releases it to 'z'.
- Received bytes are presented to local logic with a one-cycle strobe. Read bytes are requested from local logic with a one-cycle request.

Parameters:
- SLAVE_ADDR, 7'h42, 7-bit address the block responds to.
- ACK_HOLD, 300, clk cycles SDA stays low after the SCL falling edge that ends an ACK bit. Must be greater than 250 (master ACK sample point) and less than 500.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- scl  input  1  I2C clock from master
- sda  inout  1  I2C data; block drives 1'b0 or 1'bz only
- rx_data  output  8  last byte written by master
- rx_valid  output  1  one-cycle pulse: rx_data updated
- tx_data  input  8  byte to return on a read; sampled when loaded
- tx_req  output  1  one-cycle pulse: local logic must present the next read byte on tx_data
- busy  output  1  high from address match until STOP/START/NACK
- stop_det  output  1  one-cycle pulse on a STOP condition

Behaviour:
- Reset values: one clock; reset is synchronous and active-high. All outputs reset to 0 (rx_data 8'h00), sda released, FSM in IDLE, bit/hold counters cleared. Reset asserted mid-transfer releases sda on the next clock edge.
- Input conditioning: scl and sda each pass through a 2-flop synchronizer plus one delay flop. All edge/condition events act 3 clk after the pin change.
- START: synced sda falls while synced scl is high. From any state this enters ADDR, clears the bit counter and releases sda. A repeated START is handled the same way.
- STOP: synced sda rises while synced scl is high. From any state this goes to IDLE, releases sda, clears busy and pulses stop_det.
- Bit timing: sample sda on the detected scl rising edge. Change the driven sda only on the detected scl falling edge, or at ACK_HOLD expiry.
- FSM states: IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE.
- IDLE: sda released; waits for START.
- ADDR: shifts 8 bits MSB-first; bit 0 is R/W.
  - On the 8th rise: if addr[7:1] == SLAVE_ADDR, set busy and latch rw.
  - If the address does not match, go to IGNORE (sda stays released until START/STOP).
  - On the falling edge after the 8th bit (match only), drive sda low and go to ADDR_ACK.
- ADDR_ACK: holds sda low through SCL high.
  - At the next scl falling edge, start the hold counter. After ACK_HOLD cycles: rw=0 → release sda, go to WR_DATA; rw=1 → drive tx bit 7, go to RD_DATA.
  - tx_req pulses on the scl rising edge of the ACK bit. tx_data is loaded into the shift register when the hold counter expires.
- WR_DATA: shifts 8 bits.
  - On the 8th rise: rx_data <= shifted byte, rx_valid pulses that same cycle.
  - On the following fall: drive sda low and go to WR_ACK. Every write byte is ACKed.
- WR_ACK: same hold rule as ADDR_ACK, then release sda and return to WR_DATA.
- RD_DATA: on each scl fall, shift out the next bit. A '1' bit releases sda; a '0' bit drives low. After the 8th bit's fall, release sda and go to RD_ACK.
- RD_ACK: sample the master's ACK on the scl rise.
  - ACK (0): pulse tx_req; after the fall plus ACK_HOLD, load tx_data, drive bit 7, go to RD_DATA.
  - NACK (1): clear busy, go to IGNORE and wait for STOP/START.
- Bit counter: 3-bit, wraps 7→0 at each byte boundary. Hold counter is sized for ACK_HOLD, saturates, and restarts only on a new ACK.
- Simultaneous events: START/STOP take priority over any data/ACK action in the same cycle. rx_valid and stop_det are never high together, because STOP cannot occur on the 8th rise.

Test Plan:
- Write: START, 0x84, 0xA5, STOP → sda low on both 9th bits; rx_data=0xA5 with exactly one rx_valid pulse; one stop_det pulse; busy 1→0.
- Address mismatch: START, 0x86, 0x11, STOP → sda never driven; no rx_valid, tx_req or busy; stop_det pulses.
- Read: START, 0x85, tx_data=0x3C, master NACK → ACK low, then sda bits 0,0,1,1,1,1,0,0; tx_req pulses once per byte requested; sda released after NACK; busy 0.
- Repeated START: write 0x84/0x5A, then restart 0x85, read tx_data=0xC3 → rx_data=0x5A, then read bits match 0xC3, with no stop_det between the two transfers.
- ACK timing: measure sda low after the ACK-bit scl fall → exactly ACK_HOLD (300) clk cycles ±1, then release (write) or bit 7 (read).
- Reset mid-byte while sda is driven low → sda='z' the next cycle, all outputs 0; a following START, 0x84, 0x01 works normally.
